// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Handshaked pipeline boundary register used between core stages (IF/ID,
// ID/EX, EX/MEM, MEM/WB). It moves an opaque payload and a control bundle
// across one clock edge under valid/ready flow control. It supports a
// synchronous flush and zeroes control whenever the stage holds a bubble.
// It also keeps a saturating stall-cycle counter for performance debug.
//
// Optional feature macro: PIPE_STAGE_SKID_EN
//   Undefined (default): single main register, capacity 1. o_up_ready is
//                        combinational from i_dn_ready.
//   Defined            : adds a one-entry skid register, capacity 2.
//                        o_up_ready is a pure register output (~skid valid).
//
// Parameters
//   DATA_W : payload width
//   CTRL_W : control bundle width (zero whenever the stage holds a bubble)
//   CNT_W  : stall counter width (saturating)
//
// Ports
//   i_clk       : clock, rising edge
//   i_rst       : asynchronous active-high reset
//   i_up_valid  : upstream presents an entry
//   o_up_ready  : stage accepts the upstream entry this cycle
//   i_up_data   : upstream payload
//   i_up_ctrl   : upstream control bundle
//   i_flush     : kill every entry held in this stage (highest priority)
//   o_dn_valid  : stage holds a valid entry for downstream
//   i_dn_ready  : downstream consumes o_dn_* this cycle
//   o_dn_data   : registered payload
//   o_dn_ctrl   : registered control, zero when o_dn_valid is low
//   o_stall_cnt : cycles with o_dn_valid high and i_dn_ready low
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_up_valid,
   output logic              o_up_ready,
   input  logic [DATA_W-1:0] i_up_data,
   input  logic [CTRL_W-1:0] i_up_ctrl,
   input  logic              i_flush,
   output logic              o_dn_valid,
   input  logic              i_dn_ready,
   output logic [DATA_W-1:0] o_dn_data,
   output logic [CTRL_W-1:0] o_dn_ctrl,
   output logic [CNT_W-1:0]  o_stall_cnt
);

   // Main register (M): drives the downstream outputs directly.
   logic              r_mValid;
   logic [DATA_W-1:0] r_mData;
   logic [CTRL_W-1:0] r_mCtrl;

   // Saturating stall counter.
   logic [CNT_W-1:0]  r_stallCnt;

   // Handshake helpers.
   logic              w_upReady;
   logic              w_upXfer;
   logic              w_mLoad;
   logic              w_stall;

   // M may take a new value when it is empty or its content leaves this
   // cycle; otherwise it must hold every field.
   assign w_mLoad  = ~r_mValid | i_dn_ready;
   assign w_stall  = r_mValid & ~i_dn_ready;
   assign w_upXfer = i_up_valid & w_upReady;

`ifdef PIPE_STAGE_SKID_EN
   // Skid register (S): catches the one entry that upstream pushes in the
   // cycle before it can observe ready dropping.
   logic              r_sValid;
   logic [DATA_W-1:0] r_sData;
   logic [CTRL_W-1:0] r_sCtrl;

   // Ready depends only on stored state, so i_dn_ready never reaches
   // upstream combinationally. Accepting is possible while S is free.
   assign w_upReady = ~r_sValid;

   // M/S update. Flush beats everything. When M can load, a waiting S
   // entry goes first to preserve order. Upstream cannot transfer in that
   // case because ready is low while S is valid. When M is stuck, an
   // accepted upstream entry parks in S.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mValid <= 1'b0;
         r_mData  <= '0;
         r_mCtrl  <= '0;
         r_sValid <= 1'b0;
         r_sData  <= '0;
         r_sCtrl  <= '0;
      end else if (i_flush) begin
         r_mValid <= 1'b0;
         r_mCtrl  <= '0;
         r_sValid <= 1'b0;
         r_sCtrl  <= '0;
      end else if (w_mLoad) begin
         if (r_sValid) begin
            r_mValid <= 1'b1;
            r_mData  <= r_sData;
            r_mCtrl  <= r_sCtrl;
            r_sValid <= 1'b0;
            r_sCtrl  <= '0;
         end else if (w_upXfer) begin
            r_mValid <= 1'b1;
            r_mData  <= i_up_data;
            r_mCtrl  <= i_up_ctrl;
         end else begin
            r_mValid <= 1'b0;
            r_mCtrl  <= '0;
         end
      end else if (w_upXfer) begin
         r_sValid <= 1'b1;
         r_sData  <= i_up_data;
         r_sCtrl  <= i_up_ctrl;
      end
   end
`else
   // Without a skid slot the stage can only accept when M is free or
   // draining, which makes ready combinational from i_dn_ready.
   assign w_upReady = w_mLoad;

   // M update. Flush beats everything. On a load without an upstream
   // transfer the stage becomes a bubble: control is zeroed and data holds.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mValid <= 1'b0;
         r_mData  <= '0;
         r_mCtrl  <= '0;
      end else if (i_flush) begin
         r_mValid <= 1'b0;
         r_mCtrl  <= '0;
      end else if (w_mLoad) begin
         if (w_upXfer) begin
            r_mValid <= 1'b1;
            r_mData  <= i_up_data;
            r_mCtrl  <= i_up_ctrl;
         end else begin
            r_mValid <= 1'b0;
            r_mCtrl  <= '0;
         end
      end
   end
`endif

   // Stall counter: counts edges where a valid entry sat unconsumed,
   // including flush cycles. It sticks at all-ones and only reset clears it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stallCnt <= '0;
      end else if (w_stall && (r_stallCnt != {CNT_W{1'b1}})) begin
         r_stallCnt <= r_stallCnt + 1'b1;
      end
   end

   // Output drive.
   assign o_up_ready  = w_upReady;
   assign o_dn_valid  = r_mValid;
   assign o_dn_data   = r_mData;
   assign o_dn_ctrl   = r_mCtrl;
   assign o_stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed self-checking bench for pipe_stage_reg. The main instance uses
// default widths. A second instance with CNT_W=4 shares the same stimulus
// and is used only to observe stall-counter saturation. Skid-specific
// scenarios are selected with PIPE_STAGE_SKID_EN, matching the RTL build.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 8;
   localparam int CNT_W  = 16;

   logic              i_clk;
   logic              i_rst;
   logic              i_up_valid;
   logic              o_up_ready;
   logic [DATA_W-1:0] i_up_data;
   logic [CTRL_W-1:0] i_up_ctrl;
   logic              i_flush;
   logic              o_dn_valid;
   logic              i_dn_ready;
   logic [DATA_W-1:0] o_dn_data;
   logic [CTRL_W-1:0] o_dn_ctrl;
   logic [CNT_W-1:0]  o_stall_cnt;

   logic              satUpReady;
   logic              satDnValid;
   logic [DATA_W-1:0] satDnData;
   logic [CTRL_W-1:0] satDnCtrl;
   logic [3:0]        satStallCnt;

   int checkCnt;
   int passCnt;

   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_up_valid  (i_up_valid),
      .o_up_ready  (o_up_ready),
      .i_up_data   (i_up_data),
      .i_up_ctrl   (i_up_ctrl),
      .i_flush     (i_flush),
      .o_dn_valid  (o_dn_valid),
      .i_dn_ready  (i_dn_ready),
      .o_dn_data   (o_dn_data),
      .o_dn_ctrl   (o_dn_ctrl),
      .o_stall_cnt (o_stall_cnt)
   );

   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(4)) dutSat (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_up_valid  (i_up_valid),
      .o_up_ready  (satUpReady),
      .i_up_data   (i_up_data),
      .i_up_ctrl   (i_up_ctrl),
      .i_flush     (i_flush),
      .o_dn_valid  (satDnValid),
      .i_dn_ready  (i_dn_ready),
      .o_dn_data   (satDnData),
      .o_dn_ctrl   (satDnCtrl),
      .o_stall_cnt (satStallCnt)
   );

   // 10 ns clock.
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Advance to just after the next rising edge so that outputs are stable.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Reset pulse with idle inputs; released just after an edge.
   task automatic doReset();
      i_rst      = 1'b1;
      i_up_valid = 1'b0;
      i_up_data  = '0;
      i_up_ctrl  = '0;
      i_flush    = 1'b0;
      i_dn_ready = 1'b0;
      tick();
      i_rst = 1'b0;
   endtask

   // Reset state, then asynchronous reset in the middle of a held entry.
   task automatic test_reset();
      doReset();
      checkCnt++;
      if (o_dn_valid !== 1'b0) $display("[TB] FAIL rst_valid: got %b expected 0", o_dn_valid);
      else passCnt++;
      checkCnt++;
      if (o_dn_ctrl !== 8'h00) $display("[TB] FAIL rst_ctrl: got %h expected 00", o_dn_ctrl);
      else passCnt++;
      checkCnt++;
      if (o_dn_data !== 32'h0) $display("[TB] FAIL rst_data: got %h expected 0", o_dn_data);
      else passCnt++;
      checkCnt++;
      if (o_stall_cnt !== 16'd0) $display("[TB] FAIL rst_cnt: got %0d expected 0", o_stall_cnt);
      else passCnt++;

      i_up_valid = 1'b1;
      i_up_data  = 32'hABCD_1234;
      i_up_ctrl  = 8'hFF;
      i_dn_ready = 1'b0;
      tick();
      i_up_valid = 1'b0;
      checkCnt++;
      if (o_dn_valid !== 1'b1 || o_dn_ctrl !== 8'hFF)
         $display("[TB] FAIL mid_load: got valid=%b ctrl=%h expected valid=1 ctrl=ff", o_dn_valid, o_dn_ctrl);
      else passCnt++;
      tick();
      checkCnt++;
      if (o_stall_cnt !== 16'd1) $display("[TB] FAIL mid_cnt: got %0d expected 1", o_stall_cnt);
      else passCnt++;

      #3;
      i_rst = 1'b1;
      #1;
      checkCnt++;
      if (o_dn_valid !== 1'b0 || o_dn_ctrl !== 8'h00 || o_dn_data !== 32'h0 || o_stall_cnt !== 16'd0)
         $display("[TB] FAIL async_rst: got valid=%b ctrl=%h data=%h cnt=%0d expected all zero",
                  o_dn_valid, o_dn_ctrl, o_dn_data, o_stall_cnt);
      else passCnt++;
      tick();
      i_rst = 1'b0;
   endtask

   // Ten back-to-back entries; each visible one edge after acceptance.
   task automatic test_streaming();
      logic [31:0] expData;
      logic [7:0]  expCtrl;
      doReset();
      i_dn_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         expData    = 32'h0000_1000 + 32'(k);
         expCtrl    = 8'h10 + 8'(k);
         i_up_valid = 1'b1;
         i_up_data  = expData;
         i_up_ctrl  = expCtrl;
         #1;
         checkCnt++;
         if (o_up_ready !== 1'b1) $display("[TB] FAIL stream_ready[%0d]: got %b expected 1", k, o_up_ready);
         else passCnt++;
         tick();
         checkCnt++;
         if (o_dn_valid !== 1'b1 || o_dn_data !== expData || o_dn_ctrl !== expCtrl)
            $display("[TB] FAIL stream_out[%0d]: got valid=%b data=%h ctrl=%h expected valid=1 data=%h ctrl=%h",
                     k, o_dn_valid, o_dn_data, o_dn_ctrl, expData, expCtrl);
         else passCnt++;
      end
      i_up_valid = 1'b0;
      tick();
      checkCnt++;
      if (o_dn_valid !== 1'b0 || o_dn_ctrl !== 8'h00)
         $display("[TB] FAIL stream_bubble: got valid=%b ctrl=%h expected valid=0 ctrl=00", o_dn_valid, o_dn_ctrl);
      else passCnt++;
      checkCnt++;
      if (o_dn_data !== 32'h0000_1009) $display("[TB] FAIL bubble_data_hold: got %h expected 00001009", o_dn_data);
      else passCnt++;
      checkCnt++;
      if (o_stall_cnt !== 16'd0) $display("[TB] FAIL stream_cnt: got %0d expected 0", o_stall_cnt);
      else passCnt++;
   endtask

`ifndef PIPE_STAGE_SKID_EN
   // Three-cycle downstream stall: ready low, entry held, counter +3.
   task automatic test_stall();
      doReset();
      i_dn_ready = 1'b1;
      i_up_valid = 1'b1;
      i_up_data  = 32'h0000_2000;
      i_up_ctrl  = 8'h5A;
      tick();
      i_up_data  = 32'h0000_2001;
      i_up_ctrl  = 8'h11;
      i_dn_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         checkCnt++;
         if (o_up_ready !== 1'b0) $display("[TB] FAIL stall_ready[%0d]: got %b expected 0", c, o_up_ready);
         else passCnt++;
         tick();
         checkCnt++;
         if (o_dn_valid !== 1'b1 || o_dn_data !== 32'h0000_2000 || o_dn_ctrl !== 8'h5A)
            $display("[TB] FAIL stall_hold[%0d]: got valid=%b data=%h ctrl=%h expected valid=1 data=00002000 ctrl=5a",
                     c, o_dn_valid, o_dn_data, o_dn_ctrl);
         else passCnt++;
      end
      checkCnt++;
      if (o_stall_cnt !== 16'd3) $display("[TB] FAIL stall_cnt: got %0d expected 3", o_stall_cnt);
      else passCnt++;
      i_dn_ready = 1'b1;
      #1;
      checkCnt++;
      if (o_up_ready !== 1'b1) $display("[TB] FAIL stall_release_ready: got %b expected 1", o_up_ready);
      else passCnt++;
      tick();
      i_up_valid = 1'b0;
      checkCnt++;
      if (o_dn_data !== 32'h0000_2001 || o_dn_ctrl !== 8'h11)
         $display("[TB] FAIL stall_next: got data=%h ctrl=%h expected data=00002001 ctrl=11", o_dn_data, o_dn_ctrl);
      else passCnt++;
      tick();
   endtask

   // Flush with an offered entry while ready is high: entry dropped.
   task automatic test_flush();
      doReset();
      i_dn_ready = 1'b1;
      i_up_valid = 1'b1;
      i_up_data  = 32'h0000_4000;
      i_up_ctrl  = 8'hFF;
      tick();
      i_up_valid = 1'b0;
      i_dn_ready = 1'b0;
      tick();
      i_up_valid = 1'b1;
      i_up_data  = 32'h0000_4001;
      i_up_ctrl  = 8'h33;
      i_dn_ready = 1'b1;
      i_flush    = 1'b1;
      tick();
      i_flush    = 1'b0;
      i_up_valid = 1'b0;
      checkCnt++;
      if (o_dn_valid !== 1'b0 || o_dn_ctrl !== 8'h00)
         $display("[TB] FAIL flush_out: got valid=%b ctrl=%h expected valid=0 ctrl=00", o_dn_valid, o_dn_ctrl);
      else passCnt++;
      tick();
      checkCnt++;
      if (o_dn_valid !== 1'b0) $display("[TB] FAIL flush_drop: got valid=%b expected 0", o_dn_valid);
      else passCnt++;
      checkCnt++;
      if (o_stall_cnt !== 16'd1) $display("[TB] FAIL flush_cnt: got %0d expected 1", o_stall_cnt);
      else passCnt++;
   endtask
`else
   // Stall while streaming: one entry parks in S, ready drops, order kept.
   task automatic test_skid();
      doReset();
      i_dn_ready = 1'b1;
      i_up_valid = 1'b1;
      i_up_data  = 32'h0000_3000;
      i_up_ctrl  = 8'hA0;
      tick();
      i_dn_ready = 1'b0;
      i_up_data  = 32'h0000_3001;
      i_up_ctrl  = 8'hA1;
      #1;
      checkCnt++;
      if (o_up_ready !== 1'b1) $display("[TB] FAIL skid_ready_first: got %b expected 1", o_up_ready);
      else passCnt++;
      tick();
      i_up_data = 32'h0000_3002;
      i_up_ctrl = 8'hA2;
      for (int c = 0; c < 2; c++) begin
         checkCnt++;
         if (o_up_ready !== 1'b0) $display("[TB] FAIL skid_ready_low[%0d]: got %b expected 0", c, o_up_ready);
         else passCnt++;
         checkCnt++;
         if (o_dn_data !== 32'h0000_3000 || o_dn_ctrl !== 8'hA0)
            $display("[TB] FAIL skid_hold[%0d]: got data=%h ctrl=%h expected data=00003000 ctrl=a0",
                     c, o_dn_data, o_dn_ctrl);
         else passCnt++;
         tick();
      end
      checkCnt++;
      if (o_stall_cnt !== 16'd3) $display("[TB] FAIL skid_cnt: got %0d expected 3", o_stall_cnt);
      else passCnt++;
      i_dn_ready = 1'b1;
      tick();
      checkCnt++;
      if (o_dn_valid !== 1'b1 || o_dn_data !== 32'h0000_3001 || o_dn_ctrl !== 8'hA1)
         $display("[TB] FAIL skid_s2m: got valid=%b data=%h ctrl=%h expected valid=1 data=00003001 ctrl=a1",
                  o_dn_valid, o_dn_data, o_dn_ctrl);
      else passCnt++;
      checkCnt++;
      if (o_up_ready !== 1'b1) $display("[TB] FAIL skid_ready_back: got %b expected 1", o_up_ready);
      else passCnt++;
      tick();
      i_up_valid = 1'b0;
      checkCnt++;
      if (o_dn_data !== 32'h0000_3002 || o_dn_ctrl !== 8'hA2)
         $display("[TB] FAIL skid_next: got data=%h ctrl=%h expected data=00003002 ctrl=a2", o_dn_data, o_dn_ctrl);
      else passCnt++;
      tick();
      checkCnt++;
      if (o_dn_valid !== 1'b0) $display("[TB] FAIL skid_no_dup: got valid=%b expected 0", o_dn_valid);
      else passCnt++;
   endtask

   // Flush with M and S full and upstream offering: everything dropped.
   task automatic test_flush();
      doReset();
      i_dn_ready = 1'b0;
      i_up_valid = 1'b1;
      i_up_data  = 32'h0000_4000;
      i_up_ctrl  = 8'hFF;
      tick();
      i_up_data  = 32'h0000_4001;
      i_up_ctrl  = 8'h0F;
      tick();
      i_up_data  = 32'h0000_4002;
      i_up_ctrl  = 8'h33;
      i_flush    = 1'b1;
      tick();
      i_flush    = 1'b0;
      i_up_valid = 1'b0;
      checkCnt++;
      if (o_dn_valid !== 1'b0 || o_dn_ctrl !== 8'h00)
         $display("[TB] FAIL flush_out: got valid=%b ctrl=%h expected valid=0 ctrl=00", o_dn_valid, o_dn_ctrl);
      else passCnt++;
      checkCnt++;
      if (o_up_ready !== 1'b1) $display("[TB] FAIL flush_s_empty: got ready=%b expected 1", o_up_ready);
      else passCnt++;
      i_dn_ready = 1'b1;
      tick();
      checkCnt++;
      if (o_dn_valid !== 1'b0) $display("[TB] FAIL flush_drop: got valid=%b expected 0", o_dn_valid);
      else passCnt++;
      checkCnt++;
      if (o_stall_cnt !== 16'd2) $display("[TB] FAIL flush_cnt: got %0d expected 2", o_stall_cnt);
      else passCnt++;
   endtask
`endif

   // 20-cycle stall: the 4-bit counter stops at 15, the 16-bit one reaches 20.
   task automatic test_saturation();
      doReset();
      i_dn_ready = 1'b1;
      i_up_valid = 1'b1;
      i_up_data  = 32'h0000_5000;
      i_up_ctrl  = 8'h01;
      tick();
      i_up_valid = 1'b0;
      i_dn_ready = 1'b0;
      repeat (14) tick();
      checkCnt++;
      if (satStallCnt !== 4'd14) $display("[TB] FAIL sat_14: got %0d expected 14", satStallCnt);
      else passCnt++;
      tick();
      checkCnt++;
      if (satStallCnt !== 4'd15) $display("[TB] FAIL sat_15: got %0d expected 15", satStallCnt);
      else passCnt++;
      repeat (5) tick();
      checkCnt++;
      if (satStallCnt !== 4'd15) $display("[TB] FAIL sat_hold: got %0d expected 15", satStallCnt);
      else passCnt++;
      checkCnt++;
      if (o_stall_cnt !== 16'd20) $display("[TB] FAIL wide_cnt: got %0d expected 20", o_stall_cnt);
      else passCnt++;
      i_dn_ready = 1'b1;
      tick();
   endtask

   // Scenario sequence.
   initial begin
      checkCnt   = 0;
      passCnt    = 0;
      i_rst      = 1'b1;
      i_up_valid = 1'b0;
      i_up_data  = '0;
      i_up_ctrl  = '0;
      i_flush    = 1'b0;
      i_dn_ready = 1'b0;
      test_reset();
      test_streaming();
`ifndef PIPE_STAGE_SKID_EN
      test_stall();
`else
      test_skid();
`endif
      test_flush();
      test_saturation();
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
